mem_access: RTL
===============

# mem_access

Memory-access stage of the multi-cycle core. It consumes the result and flags registered by the execute stage and runs one load or store over a ready/valid data-memory port. It performs byte/halfword lane steering, store strobes, load sign/zero extension and alignment checking. It then presents the write-back value and destination, with a one-cycle `done` pulse, to the core controller. Non-memory instructions pass the ALU result straight through.

## Interface
- No parameters; XLEN fixed at 32.
- `clk` in 1: clock, all state updates on rising edge.
- `rstn` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle pulse from the controller on entering its MEM state; sampled only in IDLE.
- `mem_read_enabled` in 1: instruction is a load.
- `mem_write_enabled` in 1: instruction is a store.
- `funct3` in 3: access size.
  - 000 b, 001 h, 010 w, 100 bu, 101 hu.
  - Stores use only 000/001/010.
- `addr` in 32: execute result; the effective address for memory ops, the ALU value otherwise.
- `store_data` in 32: rs2 value.
- `reg_write_enabled` in 1, `reg_write_dest` in 5: write-back control from execute.
- `dmem_req` out 1: request valid.
- `dmem_we` out 1: 1 store, 0 load.
- `dmem_addr` out 32: `{addr[31:2],2'b00}`.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_wstrb` out 4: byte strobes; 0000 for loads.
- `dmem_ready` in 1: memory accepts the request when `dmem_req && dmem_ready`.
- `dmem_rvalid` in 1, `dmem_rdata` in 32: load response; the word is valid for one cycle.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse; write-back outputs valid in the same cycle.
- `wb_data` out 32, `wb_enabled` out 1, `wb_dest` out 5: write-back request.
- `fault` out 1: valid with `done`; misaligned or illegal access.

## Operation
- States: IDLE, REQ, WAIT, DONE. All outputs are registered. Inputs are latched on `start` and held internally for the whole operation.
- IDLE on `start`:
  - Fault case goes to DONE with `fault=1`, `wb_enabled=0`, and no request issued. A fault is any of:
    - both enables set;
    - illegal `funct3` for the op;
    - h/hu with `addr[0]=1`;
    - w with `addr[1:0]≠0`.
  - Neither enable set goes to DONE with `wb_data=addr`, `wb_enabled=reg_write_enabled`, `wb_dest=reg_write_dest`.
  - Otherwise goes to REQ.
- REQ:
  - `dmem_req=1`; address, we, wdata and wstrb are held stable until accepted.
  - On accept, a store goes to DONE and a load goes to WAIT.
  - `dmem_rvalid` is ignored in REQ.
- WAIT: on `dmem_rvalid`, capture the extracted load value into `wb_data` and go to DONE.
- DONE: `done=1` for exactly one cycle, then IDLE.
  - A store asserts `wb_enabled=0`.
  - A load asserts `wb_enabled=reg_write_enabled`.
  - `wb_data`, `wb_dest` and `fault` hold their values until the next `start` is accepted.
- Store steering:
  - sb: wdata `{4{sd[7:0]}}`, wstrb `0001<<addr[1:0]`.
  - sh: wdata `{2{sd[15:0]}}`, wstrb `0011<<{addr[1],1'b0}`.
  - sw: wdata `sd`, wstrb `1111`.
- Load extraction:
  - Byte select `rdata >> (8*addr[1:0])`; halfword select `rdata >> (16*addr[1])`.
  - b and h sign-extend; bu and hu zero-extend; w passes through unchanged.
- `start` while `busy` is ignored.
- A `dmem_rvalid` seen in IDLE, REQ or DONE is dropped.

## Timing
- Reset (`rstn=0` at an edge):
  - State goes to IDLE.
  - `dmem_req`, `dmem_we`, `dmem_wstrb`, `busy`, `done`, `wb_enabled` and `fault` go to 0.
  - `dmem_addr`, `dmem_wdata`, `wb_data` and `wb_dest` go to 0.
  - This applies from any state, including mid-REQ (request withdrawn) and mid-WAIT (the later response is discarded).
- With `start` sampled at edge 0:
  - `busy` and `dmem_req` rise after edge 0.
  - Non-memory or fault: `done` is high in cycle 1.
  - Store with `dmem_ready` already high: accepted at edge 1, `done` in cycle 2.
  - Load with ready high and rvalid one cycle later: accepted at edge 1, rvalid sampled at edge 2, `done` in cycle 3.
- Each extra cycle of `dmem_ready=0` or of `dmem_rvalid` delay adds exactly one cycle.
- Minimum spacing between accepted `start` pulses equals the latency plus one (the IDLE cycle).

## Test plan
- Store byte lane: sb, `addr=0x1003`, `store_data=0x12345678`, ready high → `dmem_addr=0x1000`, `wstrb=1000`, `wdata=0x78787878`, `done` at cycle 2, `wb_enabled=0`.
- Load extension: `rdata=0x80FF7F01`, checked cases:
  - lb at addr 2 → `wb_data=0xFFFFFFFF`.
  - lbu at addr 2 → `0x000000FF`.
  - lh at addr 2 → `0xFFFF80FF`.
  - hu at addr 0 → `0x00007F01`.
  - lw → `0x80FF7F01`.
  - In every case `done` at cycle 3 and `wb_dest` equals the input.
- Backpressure: `dmem_ready` low for 3 cycles on sw `addr=0x20` → `dmem_req`, `dmem_addr` and `wdata` stable for all 4 request cycles, single accept, `done` at cycle 5.
- Faults, all giving `done` at cycle 1, `fault=1`, `wb_enabled=0`, and `dmem_req` never asserted:
  - lw at `0x102`;
  - lh at `0x101`;
  - `funct3=011` load;
  - both enables set.
- Pass-through: no enables, `addr=0xDEADBEEF`, `reg_write_enabled=1`, dest 7 → `done` at cycle 1, `wb_data=0xDEADBEEF`, `wb_enabled=1`, `wb_dest=7`.
- Reset mid-WAIT: deassert `rstn` for one edge after a load is accepted, then drive `dmem_rvalid` → `busy=0`, no `done`; a fresh sw afterwards completes normally.

Source files
------------

// File: rtl/mem_access_if.sv
// Data-memory port of the memory-access stage: one request channel plus
// a single-beat load response channel.
interface mem_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_ready, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_ready, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_access.sv
// Memory-access stage: runs one load/store over the data-memory port with
// lane steering, load extension and alignment checks; non-memory ops pass through.
module mem_access (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        mem_read_enabled,
  input  logic        mem_write_enabled,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic        reg_write_enabled,
  input  logic [4:0]  reg_write_dest,
  mem_access_if.master dmem,
  output logic        busy,
  output logic        done,
  output logic [31:0] wb_data,
  output logic        wb_enabled,
  output logic [4:0]  wb_dest,
  output logic        fault
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_d;
  logic        is_load, is_load_d;
  logic [2:0]  f3, f3_d;
  logic [1:0]  addr_lo, addr_lo_d;
  logic        reg_we, reg_we_d;

  logic        req_d, we_d;
  logic [31:0] dmem_addr_d, wdata_d;
  logic [3:0]  wstrb_d;
  logic        busy_d, done_d, wb_en_d, fault_d;
  logic [31:0] wb_data_d;
  logic [4:0]  wb_dest_d;

  logic        start_fault;
  logic [31:0] steer_wdata;
  logic [3:0]  steer_wstrb;
  logic [31:0] load_value;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // Alignment and encoding checks work on the live inputs since they decide the IDLE exit.
  always_comb begin
    start_fault = 1'b0;
    if (mem_read_enabled && mem_write_enabled) begin
      start_fault = 1'b1;
    end else if (mem_read_enabled || mem_write_enabled) begin
      if (mem_read_enabled && (funct3 == 3'b011 || funct3[2:1] == 2'b11))
        start_fault = 1'b1;
      if (mem_write_enabled && (funct3[2] || funct3[1:0] == 2'b11))
        start_fault = 1'b1;
      if (funct3[1:0] == 2'b01 && addr[0])
        start_fault = 1'b1;
      if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)
        start_fault = 1'b1;
    end
  end

  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        steer_wdata = {4{store_data[7:0]}};
        steer_wstrb = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        steer_wdata = {2{store_data[15:0]}};
        steer_wstrb = 4'b0011 << {addr[1], 1'b0};
      end
      default: begin
        steer_wdata = store_data;
        steer_wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    load_byte = dmem.dmem_rdata[{addr_lo, 3'b000} +: 8];
    load_half = dmem.dmem_rdata[{addr_lo[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  load_value = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_value = {{16{load_half[15]}}, load_half};
      3'b100:  load_value = {24'h0, load_byte};
      3'b101:  load_value = {16'h0, load_half};
      default: load_value = dmem.dmem_rdata;
    endcase
  end

  // NOTE: every signal gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d     = state;
    is_load_d   = is_load;
    f3_d        = f3;
    addr_lo_d   = addr_lo;
    reg_we_d    = reg_we;
    req_d       = dmem.dmem_req;
    we_d        = dmem.dmem_we;
    dmem_addr_d = dmem.dmem_addr;
    wdata_d     = dmem.dmem_wdata;
    wstrb_d     = dmem.dmem_wstrb;
    busy_d      = busy;
    done_d      = 1'b0;
    wb_data_d   = wb_data;
    wb_en_d     = wb_enabled;
    wb_dest_d   = wb_dest;
    fault_d     = fault;

    case (state)
      IDLE: begin
        if (start) begin
          busy_d    = 1'b1;
          is_load_d = mem_read_enabled;
          f3_d      = funct3;
          addr_lo_d = addr[1:0];
          reg_we_d  = reg_write_enabled;
          wb_dest_d = reg_write_dest;
          wb_en_d   = 1'b0;
          fault_d   = 1'b0;
          wb_data_d = 32'h0;
          if (start_fault) begin
            state_d = DONE;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else if (!mem_read_enabled && !mem_write_enabled) begin
            state_d   = DONE;
            done_d    = 1'b1;
            wb_data_d = addr;
            wb_en_d   = reg_write_enabled;
          end else begin
            state_d     = REQ;
            req_d       = 1'b1;
            we_d        = mem_write_enabled;
            dmem_addr_d = {addr[31:2], 2'b00};
            wdata_d     = mem_write_enabled ? steer_wdata : 32'h0;
            wstrb_d     = mem_write_enabled ? steer_wstrb : 4'b0000;
          end
        end
      end
      REQ: begin
        if (dmem.dmem_ready) begin
          req_d = 1'b0;
          if (is_load) begin
            state_d = WAIT;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      WAIT: begin
        if (dmem.dmem_rvalid) begin
          state_d   = DONE;
          done_d    = 1'b1;
          wb_data_d = load_value;
          wb_en_d   = reg_we;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        wb_en_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state           <= IDLE;
      is_load         <= 1'b0;
      f3              <= 3'b000;
      addr_lo         <= 2'b00;
      reg_we          <= 1'b0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= 32'h0;
      dmem.dmem_wdata <= 32'h0;
      dmem.dmem_wstrb <= 4'b0000;
      busy            <= 1'b0;
      done            <= 1'b0;
      wb_data         <= 32'h0;
      wb_enabled      <= 1'b0;
      wb_dest         <= 5'd0;
      fault           <= 1'b0;
    end else begin
      state           <= state_d;
      is_load         <= is_load_d;
      f3              <= f3_d;
      addr_lo         <= addr_lo_d;
      reg_we          <= reg_we_d;
      dmem.dmem_req   <= req_d;
      dmem.dmem_we    <= we_d;
      dmem.dmem_addr  <= dmem_addr_d;
      dmem.dmem_wdata <= wdata_d;
      dmem.dmem_wstrb <= wstrb_d;
      busy            <= busy_d;
      done            <= done_d;
      wb_data         <= wb_data_d;
      wb_enabled      <= wb_en_d;
      wb_dest         <= wb_dest_d;
      fault           <= fault_d;
    end
  end

endmodule
